// File: rtl/rd_pntrs_and_empty.sv
// Read-side pointer and empty-flag logic for the dual-clock FIFO. It synchronises the
// Gray write pointer, tracks the read pointer and exports the Gray read pointer.
module rd_pntrs_and_empty #(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned AWIDTH      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              rd_clk_i,
  input  logic              aclr_i,
  input  logic              rd_req_i,
  input  logic [AWIDTH:0]   wr_pntr_gray_i,
  output logic              rd_en_o,
  output logic [AWIDTH-1:0] rd_pntr_o,
  output logic [AWIDTH:0]   rd_pntr_gray_wr_o,
  output logic              rd_empty_o,
  output logic [AWIDTH-1:0] rd_usedw_o
);

  localparam int unsigned PW = AWIDTH + 1;

  if (SYNC_STAGES < 2 || DWIDTH < 1) begin : g_param_check
    $error("rd_pntrs_and_empty: SYNC_STAGES must be >= 2 and DWIDTH >= 1");
  end

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wr_gray_s;
  logic [PW-1:0] wr_bin_s;
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic          empty_q, empty_d;
  logic          rd_take;

  // Write-pointer synchroniser; every stage clears on reset.
  always_ff @(posedge rd_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wr_pntr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wr_gray_s = sync_q[SYNC_STAGES-1];
  assign wr_bin_s  = gray2bin(wr_gray_s);

  // Next-state pointer drives empty so the final read flags empty on its own edge.
  always_comb begin
    rd_take   = rd_req_i & ~empty_q;
    rd_bin_d  = rd_bin_q + PW'(rd_take);
    rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
    empty_d   = (rd_gray_d == wr_gray_s);
  end

  always_ff @(posedge rd_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      empty_q   <= 1'b1;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      empty_q   <= empty_d;
    end
  end

  // A completely full FIFO wraps the count to 0 while empty stays low.
  assign rd_en_o           = rd_take;
  assign rd_pntr_o         = rd_bin_q[AWIDTH-1:0];
  assign rd_pntr_gray_wr_o = rd_gray_q;
  assign rd_empty_o        = empty_q;
  assign rd_usedw_o        = AWIDTH'(wr_bin_s - rd_bin_q);

endmodule

// File: tb/tb_rd_pntrs_and_empty.sv
// Bench for rd_pntrs_and_empty: directed steps plus randomised streaming, checked
// against a count-based model of the read side.
module tb_rd_pntrs_and_empty;

  localparam int unsigned AW = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned PW = AW + 1;

  logic          rd_clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          aclr_i = 1'b0;
  logic          rd_req_i = 1'b0;
  logic [PW-1:0] wr_pntr_gray_i = '0;
  logic          rd_en_o;
  logic [AW-1:0] rd_pntr_o;
  logic [PW-1:0] rd_pntr_gray_wr_o;
  logic          rd_empty_o;
  logic [AW-1:0] rd_usedw_o;

  rd_pntrs_and_empty #(.DWIDTH(8), .AWIDTH(AW), .SYNC_STAGES(SS)) dut (
    .rd_clk_i          (rd_clk),
    .aclr_i            (aclr_i),
    .rd_req_i          (rd_req_i),
    .wr_pntr_gray_i    (wr_pntr_gray_i),
    .rd_en_o           (rd_en_o),
    .rd_pntr_o         (rd_pntr_o),
    .rd_pntr_gray_wr_o (rd_pntr_gray_wr_o),
    .rd_empty_o        (rd_empty_o),
    .rd_usedw_o        (rd_usedw_o)
  );

  always #5 rd_clk = clk_en ? ~rd_clk : 1'b0;

  // Model: read count, write count as seen after the synchroniser delay, empty flag.
  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  int unsigned   rd_cnt;
  int unsigned   samples[$];
  logic          exp_empty;
  logic [PW-1:0] wr_bin = '0;
  logic [PW-1:0] prev_gray;
  bit            saw_wrap = 0;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic int unsigned vis_wr();
    return samples[SS-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    check("rd_en",    32'(rd_en_o),           32'(rd_req_i && !exp_empty));
    check("rd_pntr",  32'(rd_pntr_o),         32'(rd_cnt % (1 << AW)));
    check("rd_gray",  32'(rd_pntr_gray_wr_o), 32'(to_gray(PW'(rd_cnt))));
    check("rd_empty", 32'(rd_empty_o),        32'(exp_empty));
    check("rd_usedw", 32'(rd_usedw_o),        32'((vis_wr() + 32 - rd_cnt) % (1 << AW)));
  endtask

  task automatic model_reset();
    rd_cnt    = 0;
    exp_empty = 1'b1;
    samples   = {};
    for (int i = 0; i < int'(SS); i++) samples.push_front(0);
    prev_gray = '0;
  endtask

  // One clock: drive inputs, check the strobe before the edge, update model, check after.
  task automatic cyc(input bit req);
    int unsigned vis_before;
    bit          take;
    rd_req_i       = req;
    wr_pntr_gray_i = to_gray(wr_bin);
    #1;
    check("rd_en_pre", 32'(rd_en_o), 32'(req && !exp_empty));
    @(posedge rd_clk);
    vis_before = vis_wr();
    take       = req && !exp_empty;
    if (take && (rd_cnt % 16) == 15) saw_wrap = 1;
    rd_cnt     = (rd_cnt + 32'(take)) % 32;
    exp_empty  = (rd_cnt == vis_before);
    samples.push_front(int'(wr_bin));
    void'(samples.pop_back());
    #1;
    check_all();
    check("gray_step", 32'($countones(rd_pntr_gray_wr_o ^ prev_gray)), 32'(take));
    prev_gray = rd_pntr_gray_wr_o;
  endtask

  task automatic do_reset();
    rd_req_i       = 1'b0;
    wr_bin         = '0;
    wr_pntr_gray_i = '0;
    #2 aclr_i = 1'b1;
    model_reset();
    #1 check_all();
    #2 aclr_i = 1'b0;
  endtask

  initial begin
    int unsigned writes;
    model_reset();

    // Reset with the clock stopped.
    do_reset();
    clk_en = 1'b1;
    repeat (3) cyc(0);

    // Single word arrival: count after edge 2, empty drops after edge 3.
    wr_bin = 1;
    cyc(0);
    check("arr_e1_usedw", 32'(rd_usedw_o), 0);
    cyc(0);
    check("arr_e2_usedw", 32'(rd_usedw_o), 1);
    check("arr_e2_empty", 32'(rd_empty_o), 1);
    cyc(0);
    check("arr_e3_empty", 32'(rd_empty_o), 0);

    // Single read empties on the same edge.
    cyc(1);
    check("rd1_pntr",  32'(rd_pntr_o), 1);
    check("rd1_gray",  32'(rd_pntr_gray_wr_o), 32'h01);
    check("rd1_empty", 32'(rd_empty_o), 1);
    check("rd1_usedw", 32'(rd_usedw_o), 0);

    // Underflow requests are ignored.
    repeat (10) cyc(1);
    check("uf_pntr", 32'(rd_pntr_o), 1);

    // Random streaming of 40 writes across the pointer wrap.
    writes = 0;
    for (int c = 0; c < 400 && writes < 40; c++) begin
      if (((32'(wr_bin) + 32 - rd_cnt) % 32) < 16 && $urandom_range(0, 3) != 0) begin
        wr_bin = wr_bin + 1'b1;
        writes++;
      end
      cyc($urandom_range(0, 3) != 0);
    end
    check("wrap_writes", writes, 40);
    repeat (30) cyc(1);
    check("wrap_seen",  32'(saw_wrap), 1);
    check("drain_pntr", 32'(rd_pntr_o), 32'(41 % 16));
    check("drain_empty", 32'(rd_empty_o), 1);

    // Completely full: count wraps to 0, empty low; 16 reads empty on the 16th edge.
    do_reset();
    wr_bin = 16;
    repeat (3) cyc(0);
    check("full_usedw", 32'(rd_usedw_o), 0);
    check("full_empty", 32'(rd_empty_o), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (i == 14) check("full_15_empty", 32'(rd_empty_o), 0);
    end
    check("full_16_empty", 32'(rd_empty_o), 1);
    check("full_16_gray",  32'(rd_pntr_gray_wr_o), 32'h18);

    // Reset in the middle of a read burst.
    do_reset();
    wr_bin = 16;
    repeat (3) cyc(0);
    repeat (8) cyc(1);
    check("mid_pntr", 32'(rd_pntr_o), 8);
    #2 aclr_i = 1'b1;
    #1;
    check("mid_rst_pntr",  32'(rd_pntr_o), 0);
    check("mid_rst_gray",  32'(rd_pntr_gray_wr_o), 0);
    check("mid_rst_empty", 32'(rd_empty_o), 1);
    check("mid_rst_usedw", 32'(rd_usedw_o), 0);
    check("mid_rst_en",    32'(rd_en_o), 0);
    wr_bin         = '0;
    wr_pntr_gray_i = '0;
    model_reset();
    #2 aclr_i = 1'b0;
    repeat (4) cyc(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rd_pntrs_and_empty.md
# rd_pntrs_and_empty

Read-domain pointer and status block of the dual-clock FIFO: the read-side counterpart of the write pointer / full-flag logic. It holds the binary read pointer and drives the RAM read address. It synchronises the incoming Gray write pointer into the read clock domain and generates a registered empty flag and a read-side fill count. It also exports the registered Gray read pointer back to the write domain.

## Interface
- DWIDTH, 8, FIFO data width; kept for parameter-list uniformity across FIFO sub-blocks, no functional effect here
- AWIDTH, 4, RAM address width; FIFO depth = 2**AWIDTH; pointers are AWIDTH+1 bits (extra wrap bit)
- SYNC_STAGES, 2, number of flops in the write-pointer synchroniser; legal values are 2 or more

Ports:
- rd_clk_i  in  1  read-domain clock; all flops sample on the rising edge; one clock only
- aclr_i  in  1  asynchronous, active-high reset
- rd_req_i  in  1  read request from the FIFO user
- wr_pntr_gray_i  in  AWIDTH+1  Gray write pointer, registered in the write domain, not yet synchronised
- rd_en_o  out  1  RAM read strobe = rd_req_i & ~rd_empty_o (combinational)
- rd_pntr_o  out  AWIDTH  RAM read address = rd_pntr_bin[AWIDTH-1:0]
- rd_pntr_gray_wr_o  out  AWIDTH+1  registered Gray read pointer, sent to the write domain
- rd_empty_o  out  1  registered empty flag
- rd_usedw_o  out  AWIDTH  words available, as seen by the read domain

## Operation
- Synchroniser: a chain of SYNC_STAGES flops samples wr_pntr_gray_i, and each flop resets to 0. The last stage is wr_gray_s. No other logic reads wr_pntr_gray_i.
- Write pointer conversion: wr_bin_s = gray2bin(wr_gray_s), where bit i is the XOR of wr_gray_s[AWIDTH:i].
- Read pointer:
  - rd_pntr_bin_next = rd_pntr_bin + 1 when rd_req_i & ~rd_empty_o; otherwise it holds.
  - The increment is modulo 2**(AWIDTH+1); a wrap is natural overflow.
- Gray pointer: rd_pntr_gray_next = rd_pntr_bin_next ^ (rd_pntr_bin_next >> 1). It is registered into rd_pntr_gray_wr_o on the same edge as rd_pntr_bin.
- Empty:
  - rd_empty_o is registered from (rd_pntr_gray_next == wr_gray_s).
  - The next-state pointer is used, so the read that removes the last word asserts empty on that same edge.
- Underflow: rd_req_i while rd_empty_o=1 is ignored. The pointer does not change and rd_en_o=0.
- Fill count:
  - rd_usedw_o = (wr_bin_s - rd_pntr_bin) truncated to AWIDTH bits; it is combinational from registered values.
  - When the FIFO is completely full (difference = 2**AWIDTH), rd_usedw_o reads 0 with rd_empty_o=0. This is the required behaviour, and it matches the write-side count width.
- Reset values:
  - rd_pntr_bin=0, rd_pntr_o=0, rd_pntr_gray_wr_o=0.
  - All synchroniser stages = 0.
  - rd_empty_o=1, rd_usedw_o=0, rd_en_o=0.
- Reset mid-operation: all state clears immediately on aclr_i rise, without waiting for a clock. Pending synchroniser contents are discarded.

## Timing
- Read latency of this block: rd_en_o and rd_pntr_o are valid in the same cycle as rd_req_i. The RAM captures data on that rd_clk_i edge, and the pointer advances on that same edge.
- Write-to-visible latency: a wr_pntr_gray_i change that is stable before rd_clk_i edge 1 behaves as follows (SYNC_STAGES=2):
  - it reaches wr_gray_s after edge 2;
  - rd_usedw_o updates after edge 2;
  - rd_empty_o deasserts after edge 3.
  - In general: SYNC_STAGES edges for rd_usedw_o, SYNC_STAGES+1 edges for rd_empty_o.
- Back-to-back reads: one word per cycle while rd_empty_o=0. No bubble is inserted at the pointer wrap.
- Simultaneous write arrival and final read: if wr_gray_s advances on the same edge that the last word is read, empty is evaluated against the old wr_gray_s. Empty may assert for one cycle and then deassert on the next edge. Empty is conservative only: it is never deasserted falsely.
- rd_pntr_gray_wr_o changes at most 1 bit per rd_clk_i edge.

## Test plan
- Reset: assert aclr_i with no clock running -> immediately rd_empty_o=1, rd_pntr_o=0, rd_pntr_gray_wr_o=5'b00000, rd_usedw_o=0, rd_en_o=0.
- Single word arrival (AWIDTH=4, SYNC_STAGES=2): wr_pntr_gray_i 00000->00001 -> rd_usedw_o=1 after edge 2, rd_empty_o=0 after edge 3.
- Single read: with 1 word stored, pulse rd_req_i for one cycle -> rd_en_o=1 that cycle; after the edge rd_pntr_o=1, rd_pntr_gray_wr_o=00001, rd_empty_o=1 (same edge), rd_usedw_o=0.
- Underflow: hold rd_req_i=1 for 10 cycles while empty -> rd_en_o=0 throughout; rd_pntr_o, rd_pntr_gray_wr_o and rd_empty_o stay unchanged.
- Wrap: stream 40 writes and read continuously -> rd_pntr_o follows 15->0; rd_pntr_gray_wr_o steps 10000 (bin 31) ->00000; every gray step changes exactly 1 bit; rd_empty_o asserts only when the pointers match.
- Full and mid-reset:
  - wr_pntr_gray_i=11000 (bin 16) with the read pointer at 0 -> rd_usedw_o=0, rd_empty_o=0.
  - 16 reads -> empty on the 16th edge.
  - aclr_i pulse after 8 reads -> all outputs return to their reset values at once.
